// File: rtl/motion_pkg.sv
// Shared state type and default tuning constants for the player motion block.
package motion_pkg;

   typedef enum logic {
      GROUND = 1'b0,
      AIR    = 1'b1
   } motion_state_t;

   localparam int DEF_Y_GROUND = 400;
   localparam int DEF_X_MAX    = 600;
   localparam int DEF_JUMP_V0  = 12;
   localparam int DEF_GRAVITY  = 1;

endpackage

// File: rtl/input_qualifier.sv
// Debounces an analyser level: qualified once the level has been high on
// HOLD consecutive frame ticks, counting the tick being evaluated.
module input_qualifier #(
   parameter int HOLD = 2
) (
   input  logic clk_50,
   input  logic resetn,
   input  logic frame_tick,
   input  logic level,
   output logic qualified
);

   localparam logic [2:0] HOLD_C  = 3'(HOLD);
   localparam logic [2:0] HOLD_M1 = 3'(HOLD - 1);

   logic [2:0] cnt;

   // Combinational so the current sample counts towards the hold on this tick.
   assign qualified = frame_tick && level && (cnt >= HOLD_M1);

   // Consecutive-high counter, saturating at HOLD, cleared by a low sample.
   always_ff @(posedge clk_50) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (frame_tick) begin
         if (!level) begin
            cnt <= '0;
         end else if (cnt < HOLD_C) begin
            cnt <= cnt + 3'd1;
         end
      end
   end

endmodule

// File: rtl/player_motion.sv
// Ground/air character controller: qualifies walk/jump once per frame tick,
// integrates x with wrap-around and y along an integer gravity arc.
module player_motion
   import motion_pkg::*;
#(
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int X_START   = 20,
   parameter int X_MAX     = DEF_X_MAX,
   parameter int Y_GROUND  = DEF_Y_GROUND,
   parameter int WALK_STEP = 2,
   parameter int JUMP_V0   = DEF_JUMP_V0,
   parameter int GRAVITY   = DEF_GRAVITY,
   parameter int HOLD      = 2,
   parameter int VY_W      = 6
) (
   input  logic           clk_50,
   input  logic           resetn,
   input  logic           frame_tick,
   input  logic           jump,
   input  logic           walk,
   output logic [X_W-1:0] x_pos,
   output logic [Y_W-1:0] y_pos,
   output logic           airborne,
   output logic           moving,
   output logic           land_pulse,
   output logic           pos_valid
);

   localparam logic [X_W:0]             X_MAX_C   = (X_W+1)'(X_MAX);
   localparam logic [X_W:0]             STEP_C    = (X_W+1)'(WALK_STEP);
   localparam logic [X_W-1:0]           X_START_C = X_W'(X_START);
   localparam logic signed [Y_W:0]      Y_GND_S   = (Y_W+1)'(Y_GROUND);
   localparam logic [Y_W-1:0]           Y_GND_U   = Y_W'(Y_GROUND);
   localparam logic signed [VY_W-1:0]   V0_C      = VY_W'(JUMP_V0);
   localparam logic signed [VY_W-1:0]   G_C       = VY_W'(GRAVITY);

   motion_state_t          state, state_n;
   logic                   walk_q, jump_q;
   logic                   armed, armed_n;
   logic signed [VY_W-1:0] vy, vy_n;
   logic [X_W-1:0]         x_n;
   logic [Y_W-1:0]         y_n;
   logic [X_W:0]           x_sum;
   logic signed [Y_W:0]    y_next;
   logic                   moving_n;
   logic                   land;

   input_qualifier #(.HOLD(HOLD)) u_walk_q (
      .clk_50     (clk_50),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .level      (walk),
      .qualified  (walk_q)
   );

   input_qualifier #(.HOLD(HOLD)) u_jump_q (
      .clk_50     (clk_50),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .level      (jump),
      .qualified  (jump_q)
   );

   // Frame-step update: next state, velocity, position and qualifier flags.
   always_comb begin
      state_n  = state;
      vy_n     = vy;
      x_n      = x_pos;
      y_n      = y_pos;
      armed_n  = armed;
      moving_n = moving;
      land     = 1'b0;
      x_sum    = {1'b0, x_pos} + STEP_C;
      // y is widened by one bit and vy sign-extended so the difference is signed
      y_next   = {1'b0, y_pos} - {{(Y_W+1-VY_W){vy[VY_W-1]}}, vy};

      if (frame_tick) begin
         moving_n = walk_q;
         if (walk_q) begin
            x_n = (x_sum > X_MAX_C) ? '0 : x_sum[X_W-1:0];
         end
         if (!jump) begin
            armed_n = 1'b1;
         end
         case (state)
            GROUND: begin
               if (jump_q && armed) begin
                  state_n = AIR;
                  vy_n    = V0_C;
                  armed_n = 1'b0;
               end
            end
            AIR: begin
               if (y_next >= Y_GND_S) begin
                  state_n = GROUND;
                  y_n     = Y_GND_U;
                  vy_n    = '0;
                  land    = 1'b1;
               end else begin
                  y_n  = y_next[Y_W-1:0];
                  vy_n = vy - G_C;
               end
            end
            default: state_n = GROUND;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk_50) begin
      if (!resetn) begin
         state <= GROUND;
      end else begin
         state <= state_n;
      end
   end

   // Datapath and output registers; strobes are high only after a tick.
   always_ff @(posedge clk_50) begin
      if (!resetn) begin
         x_pos      <= X_START_C;
         y_pos      <= Y_GND_U;
         vy         <= '0;
         armed      <= 1'b1;
         moving     <= 1'b0;
         land_pulse <= 1'b0;
         pos_valid  <= 1'b0;
      end else begin
         x_pos      <= x_n;
         y_pos      <= y_n;
         vy         <= vy_n;
         armed      <= armed_n;
         moving     <= moving_n;
         land_pulse <= land;
         pos_valid  <= frame_tick;
      end
   end

   assign airborne = (state == AIR);

   // The arc must never climb above row 0.
   always_ff @(posedge clk_50) begin
      if (resetn && frame_tick && state == AIR) begin
         assert (!y_next[Y_W]);
      end
   end

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion with an arc-formula reference model.
module tb_player_motion;

   localparam int HOLD_T = 2;
   localparam int V0_T   = 12;
   localparam int G_T    = 1;
   localparam int YG_T   = 400;
   localparam int XMAX_T = 600;
   localparam int STEP_T = 2;
   localparam int XST_T  = 20;

   logic       clk_50 = 1'b0;
   logic       resetn;
   logic       frame_tick;
   logic       jump;
   logic       walk;
   logic [9:0] x_pos;
   logic [8:0] y_pos;
   logic       airborne, moving, land_pulse, pos_valid;

   int errors = 0;
   int checks = 0;
   bit run = 1'b0;

   // Reference model state
   int ex, ey, wrun, jrun, k;
   bit eair, emov, eland, evalid, jlow;

   player_motion #(
      .X_START (XST_T),
      .HOLD    (HOLD_T)
   ) dut (
      .clk_50     (clk_50),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .jump       (jump),
      .walk       (walk),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .airborne   (airborne),
      .moving     (moving),
      .land_pulse (land_pulse),
      .pos_valid  (pos_valid)
   );

   always #5 clk_50 = ~clk_50;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: run lengths for qualification, closed-form height for the arc.
   always @(posedge clk_50) begin
      int h;
      if (!resetn) begin
         ex = XST_T; ey = YG_T; eair = 0; emov = 0; eland = 0; evalid = 0;
         wrun = 0; jrun = 0; k = 0; jlow = 1;
      end else begin
         evalid = frame_tick;
         eland  = 0;
         if (frame_tick) begin
            wrun = walk ? wrun + 1 : 0;
            jrun = jump ? jrun + 1 : 0;
            emov = (wrun >= HOLD_T);
            if (emov) begin
               ex = ex + STEP_T;
               if (ex > XMAX_T) ex = 0;
            end
            if (eair) begin
               k = k + 1;
               h = k * V0_T - (G_T * k * (k - 1)) / 2;
               if (h <= 0) begin
                  ey = YG_T; eair = 0; eland = 1;
               end else begin
                  ey = YG_T - h;
               end
            end else if (jrun >= HOLD_T && jlow) begin
               eair = 1; k = 0; jlow = 0;
            end
            if (!jump) jlow = 1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk_50) begin
      if (run) begin
         check("x_pos", int'(x_pos), ex);
         check("y_pos", int'(y_pos), ey);
         check("airborne", int'(airborne), int'(eair));
         check("moving", int'(moving), int'(emov));
         check("land_pulse", int'(land_pulse), int'(eland));
         check("pos_valid", int'(pos_valid), int'(evalid));
      end
   end

   task automatic step(input logic ft, input logic j, input logic w);
      @(negedge clk_50);
      frame_tick = ft; jump = j; walk = w;
      @(posedge clk_50);
      #1;
   endtask

   // Ticks with jump low until landing; returns tick index of landing and min y.
   task automatic fly(output int land_at, output int ymin);
      land_at = -1;
      ymin    = 1000;
      for (int i = 1; i <= 40; i++) begin
         step(1, 0, 0);
         if (int'(y_pos) < ymin) ymin = int'(y_pos);
         if (land_pulse) begin
            land_at = i;
            break;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int land_at, ymin, rises;
      bit prev;
      resetn = 0; frame_tick = 0; jump = 0; walk = 0;
      repeat (2) @(posedge clk_50);
      #1;
      run = 1;
      check("rst_x", int'(x_pos), 20);
      check("rst_y", int'(y_pos), 400);
      check("rst_air", int'(airborne), 0);
      check("rst_valid", int'(pos_valid), 0);
      @(negedge clk_50);
      resetn = 1;

      // Idle ticks separated by non-tick cycles
      repeat (5) begin
         step(1, 0, 0);
         check("idle_valid", int'(pos_valid), 1);
         step(0, 0, 0);
         check("idle_novalid", int'(pos_valid), 0);
      end
      check("idle_x", int'(x_pos), 20);
      check("idle_y", int'(y_pos), 400);

      // Walk for four back-to-back ticks
      step(1, 0, 1); check("walk_t1", int'(x_pos), 20); check("walk_mv1", int'(moving), 0);
      step(1, 0, 1); check("walk_t2", int'(x_pos), 22); check("walk_mv2", int'(moving), 1);
      step(1, 0, 1); check("walk_t3", int'(x_pos), 24);
      step(1, 0, 1); check("walk_t4", int'(x_pos), 26);
      step(1, 0, 0); check("walk_stop", int'(moving), 0);

      // Default jump arc
      step(1, 1, 0); check("jump_t1", int'(airborne), 0);
      step(1, 1, 0); check("takeoff", int'(airborne), 1); check("takeoff_y", int'(y_pos), 400);
      step(1, 0, 0); check("arc_t1", int'(y_pos), 388);
      fly(land_at, ymin);
      check("land_tick", land_at + 1, 25);
      check("peak_y", ymin, 322);
      check("land_y", int'(y_pos), 400);

      // Held jump gives exactly one takeoff
      rises = 0; prev = airborne;
      repeat (60) begin
         step(1, 1, 0);
         if (airborne && !prev) rises++;
         prev = airborne;
      end
      check("held_rises", rises, 1);
      check("held_ground", int'(airborne), 0);
      step(1, 0, 0);
      step(1, 1, 0); check("rejump_early", int'(airborne), 0);
      step(1, 1, 0); check("rejump", int'(airborne), 1);
      fly(land_at, ymin);
      check("rejump_land", land_at, 25);

      // Walk up to the right edge and wrap
      for (int n = 1; n <= 289; n++) begin
         step(1, 0, 1);
         if (n == 287) check("edge_598", int'(x_pos), 598);
         if (n == 288) check("edge_600", int'(x_pos), 600);
         if (n == 289) check("wrap_0", int'(x_pos), 0);
      end
      step(1, 0, 0);

      // Reset in mid-arc
      step(1, 1, 0);
      step(1, 1, 0);
      repeat (8) step(1, 0, 0);
      check("mid_arc_y", int'(y_pos), 332);
      @(negedge clk_50);
      resetn = 0; frame_tick = 1;
      @(posedge clk_50);
      #1;
      check("rst_mid_x", int'(x_pos), 20);
      check("rst_mid_y", int'(y_pos), 400);
      check("rst_mid_air", int'(airborne), 0);
      check("rst_mid_land", int'(land_pulse), 0);
      @(negedge clk_50);
      resetn = 1; frame_tick = 0;

      // Simultaneous jump and walk
      step(1, 1, 1);
      step(1, 1, 1);
      check("combo_x", int'(x_pos), 22);
      check("combo_air", int'(airborne), 1);
      step(0, 0, 0);
      step(0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
